// File: rtl/sram_template_mw.sv
// Multi-way SRAM template: per-way write-masked storage behind valid/ready read
// and write ports, with an optional post-reset zero sweep and read-data hold.

module sram_mw_way #(
    parameter int SETS   = 64,
    parameter int DATA_W = 8,
    parameter int IDX_W  = $clog2(SETS)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [IDX_W-1:0]  w_idx,
    input  logic [DATA_W-1:0] w_data,
    input  logic [IDX_W-1:0]  r_idx,
    output logic [DATA_W-1:0] r_data
);
    // Contents are deliberately not reset; the owning block sweeps them instead.
    logic [DATA_W-1:0] mem_q [SETS];

    always_ff @(posedge clock) begin
        if (we) mem_q[w_idx] <= w_data;
    end

    assign r_data = mem_q[r_idx];
endmodule

module sram_template_mw #(
    parameter int SETS         = 64,
    parameter int WAYS         = 4,
    parameter int DATA_W       = 8,
    parameter int SHOULD_RESET = 1,
    parameter int HOLD_READ    = 1,
    parameter int SINGLE_PORT  = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_r_req_valid,
    output logic                     io_r_req_ready,
    input  logic [$clog2(SETS)-1:0]  io_r_req_setIdx,
    output logic                     io_r_resp_valid,
    output logic [WAYS*DATA_W-1:0]   io_r_resp_data,
    input  logic                     io_w_req_valid,
    output logic                     io_w_req_ready,
    input  logic [$clog2(SETS)-1:0]  io_w_req_setIdx,
    input  logic [WAYS*DATA_W-1:0]   io_w_req_data,
    input  logic [WAYS-1:0]          io_w_req_waymask,
    output logic                     io_init_done
);
    localparam int IDX_W = $clog2(SETS);
    localparam int ROW_W = WAYS * DATA_W;

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    localparam state_t RST_STATE = (SHOULD_RESET != 0) ? ST_INIT : ST_RUN;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
    logic             rd_vld_q, rd_vld_d;
    logic [ROW_W-1:0] rd_data_q, rd_data_d;

    logic             run;
    logic             rd_fire;
    logic [WAYS-1:0]  way_we;
    logic [IDX_W-1:0] wr_idx;
    logic [ROW_W-1:0] wr_row;
    logic [ROW_W-1:0] rd_row;

    assign run             = (state_q == ST_RUN);
    assign io_w_req_ready  = run;
    assign io_r_req_ready  = run && !((SINGLE_PORT != 0) && io_w_req_valid);
    assign rd_fire         = io_r_req_valid && io_r_req_ready;
    assign io_init_done    = run;
    assign io_r_resp_valid = rd_vld_q;
    assign io_r_resp_data  = ((HOLD_READ != 0) || rd_vld_q) ? rd_data_q : '0;

    // The init sweep borrows the write port: all ways, zero data, set = counter.
    always_comb begin
        if (run) begin
            way_we = io_w_req_valid ? io_w_req_waymask : '0;
            wr_idx = io_w_req_setIdx;
            wr_row = io_w_req_data;
        end else begin
            way_we = '1;
            wr_idx = init_cnt_q;
            wr_row = '0;
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        sram_mw_way #(
            .SETS   (SETS),
            .DATA_W (DATA_W),
            .IDX_W  (IDX_W)
        ) u_way (
            .clock  (clock),
            .we     (way_we[w]),
            .w_idx  (wr_idx),
            .w_data (wr_row[w*DATA_W +: DATA_W]),
            .r_idx  (io_r_req_setIdx),
            .r_data (rd_row[w*DATA_W +: DATA_W])
        );
    end

    // rd_row is sampled before the same-edge write lands, giving read-before-write.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == IDX_W'(SETS - 1)) state_d = ST_RUN;
        end
        rd_vld_d  = rd_fire;
        rd_data_d = rd_fire ? rd_row : rd_data_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= RST_STATE;
            init_cnt_q <= '0;
            rd_vld_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            rd_vld_q   <= rd_vld_d;
            rd_data_q  <= rd_data_d;
        end
    end
endmodule

// File: doc/sram_template_mw.md
Name: sram_template_mw

Overview:
- Parametrised successor to the single-port SRAM template.
- Multi-way (channel) storage array with per-way write mask and valid/ready handshakes on read and write.
- Optional post-reset zero-initialisation FSM, optional read-data hold, selectable single-port or 1R1W arbitration.
- Sits under cache tag/data arrays and predictor tables; the array is an internal behavioural register array.

Parameters:
SETS, 64, number of entries per way; power of two, >=2
WAYS, 4, number of independently write-masked channels
DATA_W, 8, bits per way entry
SHOULD_RESET, 1, 1 = zero every entry after reset before accepting requests
HOLD_READ, 1, 1 = io_r_resp_data holds the last read result until the next accepted read
SINGLE_PORT, 1, 1 = one access per cycle with write priority; 0 = one read and one write per cycle

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
io_r_req_valid  in  1  read request
io_r_req_ready  out  1  read request accepted when valid&ready
io_r_req_setIdx  in  log2(SETS)  read set index
io_r_resp_valid  out  1  read data valid, 1 cycle after acceptance
io_r_resp_data  out  WAYS*DATA_W  read data; way i occupies bits [i*DATA_W +: DATA_W]
io_w_req_valid  in  1  write request
io_w_req_ready  out  1  write accepted when valid&ready
io_w_req_setIdx  in  log2(SETS)  write set index
io_w_req_data  in  WAYS*DATA_W  write data, same packing as read
io_w_req_waymask  in  WAYS  bit i=1 writes way i; other ways unchanged
io_init_done  out  1  high once the init sweep is complete (tied 1 if SHOULD_RESET=0)

Behaviour:
- States: INIT and RUN.
  - While reset=0: state=INIT if SHOULD_RESET else RUN; init counter=0; io_r_resp_valid=0; io_r_resp_data=0; io_init_done=0 (1 if SHOULD_RESET=0).
  - Array contents are not reset asynchronously.
- INIT:
  - Each cycle, write zero to all ways of set init counter, then increment the counter.
  - After writing set SETS-1: next state RUN, io_init_done=1. The sweep takes exactly SETS cycles after reset deassertion.
  - Both readies are 0 in INIT. Requests are ignored (not queued).
- RUN, write path:
  - io_w_req_ready=1 always.
  - An accepted write updates the masked ways at setIdx on that clock edge.
  - waymask=0 is accepted as a no-op.
- RUN, read path:
  - io_r_req_ready = !(SINGLE_PORT && io_w_req_valid); write has priority in single-port mode.
  - An accepted read registers the set. Next cycle: io_r_resp_valid=1 and io_r_resp_data = array contents as of the end of the accept cycle.
  - io_r_resp_valid is 1 for exactly one cycle per accepted read.
  - Back-to-back reads give one response per cycle, in order.
- Same-cycle read and write to the same set (SINGLE_PORT=0 only): the read returns the OLD data (read-before-write). No bypass.
- Read data hold:
  - HOLD_READ=1: io_r_resp_data stays at the last response value in cycles without a response, including through writes to that set.
  - HOLD_READ=0: io_r_resp_data is undefined when io_r_resp_valid=0; the bench checks it only with valid.
- Reset assertion mid-sweep or mid-read: async return to the reset values above; the sweep restarts from set 0; a pending response is dropped.
- Index width is log2(SETS). Indices wrap naturally; there is no out-of-range case.

Test Plan:
- SETS=64, SHOULD_RESET=1: release reset, hold both valids high -> readies 0 for 64 cycles, io_init_done rises on cycle 64; first read of set 63 returns all zeros.
- Write set 5 data 0x44332211 waymask 0b0101, then read set 5 -> resp_valid 1 cycle later, data 0x00330011.
- SINGLE_PORT=1, read set 5 and write set 5 (0xFFFFFFFF, mask 0xF) in the same cycle -> r_req_ready=0, write lands; read retried next cycle returns 0xFFFFFFFF.
- SINGLE_PORT=0, same-cycle read and write of set 9 (old 0x0, new 0xA5A5A5A5) -> response 0x0; following read returns 0xA5A5A5A5.
- HOLD_READ=1: read set 5 (0x00330011), idle 10 cycles, write set 5 -> io_r_resp_data stays 0x00330011 and resp_valid stays 0 throughout.
- Assert reset at sweep count 30, release -> sweep restarts and takes a full 64 cycles before io_init_done=1; readies stay 0 until then.
